// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
// Shared definitions for the fifo read/write masters:
//   - bit positions inside the fifo's 3-bit status word
//   - status value the synchronizer presets to (fifo empty)
//   - 2-bit FSM state encodings for fifo_reader
//   - helper that sizes the settle counter
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

    // Bit positions inside fifo status[2:0]
    localparam int FIFO_ST_EMPTY = 0;
    localparam int FIFO_ST_HALF  = 1;
    localparam int FIFO_ST_FULL  = 2;

    // Status assumed while reset is active: fifo empty, nothing to pop
    localparam logic [2:0] FIFO_STATUS_RST = 3'b001;

    // fifo_reader FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_POP_HI = 2'b01;
    localparam logic [1:0] ST_POP_LO = 2'b10;
    localparam logic [1:0] ST_SETTLE = 2'b11;

    // Width of a down-counter that must hold the value 'settle'; at least 1 bit
    function automatic int settle_width(input int settle);
        return (settle > 1) ? $clog2(settle + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_reader_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// W-bit multi-flop synchronizer with asynchronous active-low preset/clear.
// DEPTH = 0 turns it into a straight wire for inputs already in the clk domain.
//
// Ports
//   clk    in   1   destination clock
//   rst_n  in   1   asynchronous active-low reset; all stages load RST_VAL
//   d      in   W   asynchronous input
//   q      out  W   synchronized output (DEPTH clk of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;

            // Clock and reset have no job in the pass-through build
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
        end else begin : g_chain
            logic [W-1:0] stage [DEPTH];

            // NOTE: every stage is reset, not just the last one, so no stale
            // pre-reset value can ripple out after rst_n releases.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side master for the team fifo. Watches the fifo's (synchronized) empty
// flag, issues one clean read strobe per word on f_clk_o, and presents each
// popped word on a registered valid/ready stream.
//
// Parameters
//   n       word width, equal to the fifo's n
//   SYNC    status synchronizer depth (0 = status already in clk domain)
//   SETTLE  idle cycles after each pop before status is trusted; SETTLE >= SYNC
//
// Ports
//   clk       in   1   system clock, posedge
//   rst_n     in   1   asynchronous active-low reset
//   f_data    in   n   fifo head word
//   f_status  in   3   fifo status {full, half, empty}
//   f_clk_o   out  1   fifo read strobe; rising edge pops the head word
//   q         out  n   output word
//   q_valid   out  1   q holds an unconsumed word
//   q_ready   in   1   consumer accepts q when q_valid && q_ready at posedge
//   busy      out  1   FSM is outside IDLE
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int n      = 4,
    parameter int SYNC   = 2,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] f_data,
    input  logic [2:0]   f_status,
    output logic         f_clk_o,
    output logic [n-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy
);

    localparam int            CW          = settle_width(SETTLE);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [2:0]    status_s;
    logic          empty_s;
    logic [1:0]    state;
    logic [CW-1:0] settle_cnt;
    logic          load;

    sync_ff #(
        .W       (3),
        .DEPTH   (SYNC),
        .RST_VAL (FIFO_STATUS_RST)
    ) u_status_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (f_status),
        .q     (status_s)
    );

    assign empty_s = status_s[FIFO_ST_EMPTY];

    // Only the empty flag steers the reader; half/full are informational
    logic unused_status;
    assign unused_status = status_s[FIFO_ST_HALF] ^ status_s[FIFO_ST_FULL];

    // Pop when there is a word and the output slot is free or being freed
    // this very cycle; this is what lets accept and load overlap.
    assign load = (state == ST_IDLE) && !empty_s && (!q_valid || q_ready);

    assign busy = (state != ST_IDLE);

    // Strobe and sequencing. f_clk_o is a plain flop output, so it cannot glitch.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            f_clk_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        f_clk_o <= 1'b1;
                        state   <= ST_POP_HI;
                    end
                end
                ST_POP_HI: begin
                    f_clk_o <= 1'b0;
                    state   <= ST_POP_LO;
                end
                ST_POP_LO: begin
                    if (SETTLE == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Holds off re-evaluation until the synchronized empty flag
                    // reflects the pop just issued.
                    settle_cnt <= settle_cnt - CNT_ONE;
                    if (settle_cnt == CNT_ONE) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register. The word is captured on the same edge the strobe rises,
    // so it is the head before the fifo pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= f_data;
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
// Two readers side by side, each fed by a small behavioural fifo model
// (8 words deep): dut_a with SYNC=2/SETTLE=2 and dut_b with SYNC=0/SETTLE=0.
// Expected words are queued when written into the fifo model; per-instance
// monitors pop and compare on every accepted output word.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: SYNC=2, SETTLE=2 ----------------
    logic [3:0] fa_data, qa;
    logic [2:0] fa_status;
    logic       fa_clk_o, qa_valid, qa_ready, busy_a;

    fifo_reader #(.n(4), .SYNC(2), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .f_data(fa_data), .f_status(fa_status),
        .f_clk_o(fa_clk_o), .q(qa), .q_valid(qa_valid), .q_ready(qa_ready), .busy(busy_a)
    );

    logic [3:0] mem_a [64];
    int wr_a = 0, rd_a = 0, cnt_a;
    assign cnt_a     = wr_a - rd_a;
    assign fa_data   = mem_a[rd_a[5:0]];
    assign fa_status = {cnt_a == 8, cnt_a >= 4, cnt_a == 0};

    int pulses_a = 0, empty_pops_a = 0;
    int pop_cyc_a [16];
    always @(posedge fa_clk_o) begin
        pulses_a              <= pulses_a + 1;
        pop_cyc_a[pulses_a[3:0]] <= cyc;
        if (cnt_a == 0) empty_pops_a <= empty_pops_a + 1;
        else            rd_a         <= rd_a + 1;
    end

    logic [3:0] exp_mem_a [64];
    int exp_wr_a = 0, exp_rd_a = 0;

    task automatic push_a(input logic [3:0] v, input bit expect_it);
        mem_a[wr_a[5:0]] = v;
        wr_a++;
        if (expect_it) begin
            exp_mem_a[exp_wr_a[5:0]] = v;
            exp_wr_a++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && qa_valid && qa_ready) begin
            if (exp_rd_a == exp_wr_a) fail_now("a_unexpected_word");
            else begin
                check("a_word", qa, exp_mem_a[exp_rd_a[5:0]]);
                exp_rd_a <= exp_rd_a + 1;
            end
        end
    end

    task automatic drain_a(input string name);
        int budget;
        budget = 0;
        while (exp_rd_a != exp_wr_a && budget < 300) begin
            tick(1);
            budget++;
        end
        check(name, exp_wr_a - exp_rd_a, 0);
    endtask

    // ---------------- instance B: SYNC=0, SETTLE=0 ----------------
    logic [3:0] fb_data, qb;
    logic [2:0] fb_status;
    logic       fb_clk_o, qb_valid, qb_ready, busy_b;

    fifo_reader #(.n(4), .SYNC(0), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .f_data(fb_data), .f_status(fb_status),
        .f_clk_o(fb_clk_o), .q(qb), .q_valid(qb_valid), .q_ready(qb_ready), .busy(busy_b)
    );

    logic [3:0] mem_b [64];
    int wr_b = 0, rd_b = 0, cnt_b;
    assign cnt_b     = wr_b - rd_b;
    assign fb_data   = mem_b[rd_b[5:0]];
    assign fb_status = {cnt_b == 8, cnt_b >= 4, cnt_b == 0};

    int pulses_b = 0, empty_pops_b = 0;
    int pop_cyc_b [16];
    always @(posedge fb_clk_o) begin
        pulses_b              <= pulses_b + 1;
        pop_cyc_b[pulses_b[3:0]] <= cyc;
        if (cnt_b == 0) empty_pops_b <= empty_pops_b + 1;
        else            rd_b         <= rd_b + 1;
    end

    logic [3:0] exp_mem_b [64];
    int exp_wr_b = 0, exp_rd_b = 0;

    task automatic push_b(input logic [3:0] v);
        mem_b[wr_b[5:0]] = v;
        wr_b++;
        exp_mem_b[exp_wr_b[5:0]] = v;
        exp_wr_b++;
    endtask

    always @(negedge clk) begin
        if (rst_n && qb_valid && qb_ready) begin
            if (exp_rd_b == exp_wr_b) fail_now("b_unexpected_word");
            else begin
                check("b_word", qb, exp_mem_b[exp_rd_b[5:0]]);
                exp_rd_b <= exp_rd_b + 1;
            end
        end
    end

    task automatic drain_b(input string name);
        int budget;
        budget = 0;
        while (exp_rd_b != exp_wr_b && budget < 300) begin
            tick(1);
            budget++;
        end
        check(name, exp_wr_b - exp_rd_b, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        int budget;

        rst_n    = 1'b0;
        qa_ready = 1'b0;
        qb_ready = 1'b0;
        tick(2);
        check("rst_a_clk_o", fa_clk_o, 0);
        check("rst_a_q",     qa,       0);
        check("rst_a_valid", qa_valid, 0);
        check("rst_a_busy",  busy_a,   0);
        check("rst_b_clk_o", fb_clk_o, 0);
        check("rst_b_valid", qb_valid, 0);
        rst_n = 1'b1;
        tick(3);

        // 1: basic read-out with a ready consumer
        qa_ready = 1'b1;
        p0 = pulses_a;
        push_a(4'd4, 1); push_a(4'd2, 1); push_a(4'd0, 1); push_a(4'd6, 1);
        drain_a("t1_drain");
        check("t1_pulses", pulses_a - p0, 4);
        tick(10);
        check("t1_no_extra_pulse", pulses_a - p0, 4);
        check("t1_clk_o_idle",     fa_clk_o, 0);
        check("t1_fifo_empty",     fa_status[0], 1);

        // 2: full fifo, stalled consumer
        qa_ready = 1'b0;
        p0 = pulses_a;
        push_a(4'd1, 1); push_a(4'd3, 1); push_a(4'd5, 1);  push_a(4'd7, 1);
        push_a(4'd9, 1); push_a(4'd11, 1); push_a(4'd13, 1); push_a(4'd15, 1);
        tick(10);
        check("t2_one_pop",   pulses_a - p0, 1);
        check("t2_valid",     qa_valid, 1);
        check("t2_first",     qa, 1);
        check("t2_idle_wait", busy_a, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t2_hold", {qa_valid, qa}, {1'b1, 4'd1});
        end
        check("t2_still_one_pop", pulses_a - p0, 1);
        qa_ready = 1'b1;
        drain_a("t2_drain");
        check("t2_pulses", pulses_a - p0, 8);

        // 3: back-to-back words, accept overlaps load
        p0 = pulses_a;
        push_a(4'd9, 1); push_a(4'd1, 1); push_a(4'd3, 1);
        drain_a("t3_drain");
        check("t3_pulses",  pulses_a - p0, 3);
        check("t3_space_0", pop_cyc_a[(p0 + 1) & 15] - pop_cyc_a[p0 & 15], 5);
        check("t3_space_1", pop_cyc_a[(p0 + 2) & 15] - pop_cyc_a[(p0 + 1) & 15], 5);

        // 4: last word, no spurious second pulse
        p0 = pulses_a;
        push_a(4'd7, 1);
        drain_a("t4_drain");
        tick(15);
        check("t4_single_pulse", pulses_a - p0, 1);
        check("t4_clk_o_idle",   fa_clk_o, 0);
        check("t4_busy",         busy_a, 0);

        // 5: reset while the strobe is high; that word is lost
        qa_ready = 1'b0;
        p0 = pulses_a;
        push_a(4'd3, 0); push_a(4'd5, 1); push_a(4'd10, 1);
        budget = 0;
        while (!fa_clk_o && budget < 50) begin
            tick(1);
            budget++;
        end
        check("t5_pop_seen", fa_clk_o, 1);
        check("t5_busy_pop", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_clk_o", fa_clk_o, 0);
        check("t5_rst_valid", qa_valid, 0);
        check("t5_rst_busy",  busy_a, 0);
        check("t5_rst_q",     qa, 0);
        tick(2);
        rst_n    = 1'b1;
        qa_ready = 1'b1;
        drain_a("t5_drain");
        check("t5_pulses", pulses_a - p0, 3);

        // 6: SYNC=0, SETTLE=0 build
        qb_ready = 1'b1;
        p0 = pulses_b;
        push_b(4'd4); push_b(4'd2); push_b(4'd0); push_b(4'd6);
        drain_b("t6_drain");
        check("t6_pulses", pulses_b - p0, 4);
        for (int i = 0; i < 3; i++)
            check("t6_space", pop_cyc_b[(p0 + i + 1) & 15] - pop_cyc_b[(p0 + i) & 15], 3);
        tick(10);
        check("t6_no_extra_pulse", pulses_b - p0, 4);

        check("a_pop_on_empty", empty_pops_a, 0);
        check("b_pop_on_empty", empty_pops_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
